// File: rtl/lfsr_param_engine.sv
// Parametrised LFSR with Galois/Fibonacci stepping, seed load
// and hardware measurement of the sequence period.
module lfsr_param_engine #(
  parameter int              WIDTH        = 5,
  parameter logic [WIDTH-1:0] GAL_TAPS     = 5'b00100,
  parameter logic [WIDTH-1:0] FIB_TAPS     = 5'b10100,
  parameter logic [WIDTH-1:0] SEED_DEFAULT = 5'b00001
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  input  logic             mode,
  output logic [WIDTH-1:0] state,
  output logic             mode_q,
  output logic             wrap,
  output logic [WIDTH-1:0] period,
  output logic             period_valid,
  output logic             seed_err
);

  logic [WIDTH-1:0] r_state;
  logic [WIDTH-1:0] r_ref;
  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] r_period;
  logic             r_mode;
  logic             r_wrap;
  logic             r_pvalid;
  logic             r_serr;

  logic [WIDTH-1:0] w_gal;
  logic [WIDTH-1:0] w_fib;
  logic [WIDTH-1:0] w_next;
  logic [WIDTH-1:0] w_n;
  logic [WIDTH-1:0] w_seed;
  logic             w_seed_zero;

  // Next-state candidates for both stepping styles
  always_comb begin
    w_gal    = '0;
    w_gal[0] = r_state[WIDTH-1];
    for (int i = 1; i < WIDTH; i++) begin
      w_gal[i] = r_state[i-1] ^ (GAL_TAPS[i] & r_state[WIDTH-1]);
    end
    w_fib = {r_state[WIDTH-2:0], ^(r_state & FIB_TAPS)};
  end

  assign w_next      = r_mode ? w_fib : w_gal;
  assign w_n         = r_cnt + {{(WIDTH-1){1'b0}}, 1'b1};
  assign w_seed_zero = (seed == '0);
  assign w_seed      = w_seed_zero ? SEED_DEFAULT : seed;

  // Load, step and period-measurement state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= SEED_DEFAULT;
      r_ref    <= SEED_DEFAULT;
      r_mode   <= 1'b0;
      r_cnt    <= '0;
      r_period <= '0;
      r_pvalid <= 1'b0;
      r_wrap   <= 1'b0;
      r_serr   <= 1'b0;
    end else if (load) begin
      r_state  <= w_seed;
      r_ref    <= w_seed;
      r_mode   <= mode;
      r_cnt    <= '0;
      r_pvalid <= 1'b0;
      r_wrap   <= 1'b0;
      r_serr   <= w_seed_zero;
    end else if (en) begin
      r_state <= w_next;
      r_serr  <= 1'b0;
      if (w_next == r_ref) begin
        r_wrap   <= 1'b1;
        r_period <= w_n;
        r_pvalid <= 1'b1;
        r_cnt    <= '0;
      end else begin
        r_wrap <= 1'b0;
        r_cnt  <= w_n;
      end
    end else begin
      r_wrap <= 1'b0;
      r_serr <= 1'b0;
    end
  end

  assign state        = r_state;
  assign mode_q       = r_mode;
  assign wrap         = r_wrap;
  assign period       = r_period;
  assign period_valid = r_pvalid;
  assign seed_err     = r_serr;

endmodule

// File: tb/tb_lfsr_param_engine.sv
// Directed self-checking bench for lfsr_param_engine
// (default 5-bit configuration).
module tb_lfsr_param_engine;

  logic       clk;
  logic       rst;
  logic       en;
  logic       load;
  logic [4:0] seed;
  logic       mode;
  logic [4:0] state;
  logic       mode_q;
  logic       wrap;
  logic [4:0] period;
  logic       period_valid;
  logic       seed_err;

  int n_checks;
  int n_fail;

  lfsr_param_engine dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .load         (load),
    .seed         (seed),
    .mode         (mode),
    .state        (state),
    .mode_q       (mode_q),
    .wrap         (wrap),
    .period       (period),
    .period_valid (period_valid),
    .seed_err     (seed_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // advance one edge and settle
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst  = 1'b1;
    en   = 1'b0;
    load = 1'b0;
    seed = 5'd0;
    mode = 1'b0;
    #2;
    n_checks++;
    if (state !== 5'b00001) begin
      n_fail++;
      $display("FAIL reset_state got=%b exp=00001", state);
    end
    n_checks++;
    if ({mode_q, wrap, period_valid, seed_err} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_flags got=%b exp=0000",
               {mode_q, wrap, period_valid, seed_err});
    end
    n_checks++;
    if (period !== 5'd0) begin
      n_fail++;
      $display("FAIL reset_period got=%0d exp=0", period);
    end
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_galois_steps();
    logic [4:0] exp_seq [5];
    exp_seq = '{5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b00101};
    en = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      n_checks++;
      if (state !== exp_seq[k]) begin
        n_fail++;
        $display("FAIL gal_step%0d got=%b exp=%b", k, state, exp_seq[k]);
      end
    end
    en = 1'b0;
  endtask

  task automatic test_galois_period();
    bit [31:0] vis;
    int        first_wrap;
    int        wraps;
    vis        = '0;
    first_wrap = 0;
    wraps      = 0;
    load = 1'b1;
    seed = 5'b00001;
    mode = 1'b0;
    tick();
    load = 1'b0;
    n_checks++;
    if (state !== 5'b00001 || mode_q !== 1'b0 || period_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL gal_load got=%b/%b/%b exp=00001/0/0",
               state, mode_q, period_valid);
    end
    en = 1'b1;
    for (int k = 1; k <= 62; k++) begin
      tick();
      if (k <= 31) vis[state] = 1'b1;
      if (wrap === 1'b1) begin
        wraps++;
        if (first_wrap == 0) first_wrap = k;
      end
      if (k == 30) begin
        n_checks++;
        if (period_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL gal_pv_early got=%b exp=0", period_valid);
        end
      end
      if (k == 31) begin
        n_checks++;
        if (period !== 5'd31 || period_valid !== 1'b1 || state !== 5'b00001) begin
          n_fail++;
          $display("FAIL gal_wrap31 got=%0d/%b/%b exp=31/1/00001",
                   period, period_valid, state);
        end
      end
    end
    en = 1'b0;
    n_checks++;
    if (first_wrap != 31 || wraps != 2) begin
      n_fail++;
      $display("FAIL gal_wrap_count got=first%0d,n%0d exp=first31,n2",
               first_wrap, wraps);
    end
    n_checks++;
    if (vis !== 32'hFFFF_FFFE) begin
      n_fail++;
      $display("FAIL gal_visited got=%h exp=fffffffe", vis);
    end
  endtask

  task automatic test_fibonacci();
    int first_wrap;
    first_wrap = 0;
    load = 1'b1;
    seed = 5'b00001;
    mode = 1'b1;
    tick();
    load = 1'b0;
    mode = 1'b0;
    n_checks++;
    if (mode_q !== 1'b1) begin
      n_fail++;
      $display("FAIL fib_mode_q got=%b exp=1", mode_q);
    end
    en = 1'b1;
    tick();
    n_checks++;
    if (state !== 5'b00010) begin
      n_fail++;
      $display("FAIL fib_step1 got=%b exp=00010", state);
    end
    mode = 1'b1;
    tick();
    mode = 1'b0;
    tick();
    n_checks++;
    if (state !== 5'b01001 || mode_q !== 1'b1) begin
      n_fail++;
      $display("FAIL fib_step3 got=%b/%b exp=01001/1", state, mode_q);
    end
    for (int k = 4; k <= 31; k++) begin
      tick();
      if (wrap === 1'b1 && first_wrap == 0) first_wrap = k;
    end
    en = 1'b0;
    n_checks++;
    if (first_wrap != 31 || period !== 5'd31 || period_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL fib_period got=wrap%0d,p%0d,v%b exp=wrap31,p31,v1",
               first_wrap, period, period_valid);
    end
  endtask

  task automatic test_zero_seed();
    load = 1'b1;
    seed = 5'b00000;
    mode = 1'b0;
    tick();
    load = 1'b0;
    n_checks++;
    if (state !== 5'b00001 || seed_err !== 1'b1 || period_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_load got=%b/%b/%b exp=00001/1/0",
               state, seed_err, period_valid);
    end
    n_checks++;
    if (period !== 5'd31) begin
      n_fail++;
      $display("FAIL zero_period_kept got=%0d exp=31", period);
    end
    tick();
    n_checks++;
    if (seed_err !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_err_pulse got=%b exp=0", seed_err);
    end
  endtask

  task automatic test_collision();
    int first_wrap;
    int bad;
    first_wrap = 0;
    bad        = 0;
    en   = 1'b1;
    load = 1'b1;
    seed = 5'b10101;
    mode = 1'b0;
    tick();
    load = 1'b0;
    en   = 1'b0;
    n_checks++;
    if (state !== 5'b10101 || wrap !== 1'b0) begin
      n_fail++;
      $display("FAIL coll_load got=%b/%b exp=10101/0", state, wrap);
    end
    for (int k = 0; k < 10; k++) begin
      tick();
      if (state !== 5'b10101) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL gated_hold got=%0d_changes exp=0", bad);
    end
    en = 1'b1;
    tick();
    n_checks++;
    if (state !== 5'b01111) begin
      n_fail++;
      $display("FAIL coll_step1 got=%b exp=01111", state);
    end
    for (int k = 2; k <= 31; k++) begin
      tick();
      if (wrap === 1'b1 && first_wrap == 0) first_wrap = k;
    end
    en = 1'b0;
    n_checks++;
    if (first_wrap != 31 || state !== 5'b10101) begin
      n_fail++;
      $display("FAIL coll_count got=wrap%0d,s%b exp=wrap31,s10101",
               first_wrap, state);
    end
  endtask

  task automatic test_reset_mid_run();
    logic [4:0] exp_seq [3];
    exp_seq = '{5'b00010, 5'b00100, 5'b01000};
    load = 1'b1;
    seed = 5'b00001;
    mode = 1'b1;
    tick();
    load = 1'b0;
    en   = 1'b1;
    for (int k = 0; k < 17; k++) tick();
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (state !== 5'b00001 || period !== 5'd0 ||
        {mode_q, wrap, period_valid, seed_err} !== 4'b0000) begin
      n_fail++;
      $display("FAIL midrst_vals got=%b/%0d/%b exp=00001/0/0000", state,
               period, {mode_q, wrap, period_valid, seed_err});
    end
    tick();
    n_checks++;
    if (state !== 5'b00001) begin
      n_fail++;
      $display("FAIL midrst_hold got=%b exp=00001", state);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++;
      if (state !== exp_seq[k] || mode_q !== 1'b0) begin
        n_fail++;
        $display("FAIL midrst_step%0d got=%b/%b exp=%b/0",
                 k, state, mode_q, exp_seq[k]);
      end
    end
    en = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_galois_steps();
    test_galois_period();
    test_fibonacci();
    test_zero_seed();
    test_collision();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
